// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the serial add/subtract engine:
// FSM state encoding, mode constants and the signed-overflow rule.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Two's-complement overflow: same-sign operands yielding an opposite-sign sum.
  function automatic logic overflow_f(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// The slave modport is the engine side, the master modport is the producer/consumer side.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
) ();

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_mode;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;
  logic             o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_mode, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_overflow, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_mode, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_overflow, o_busy
  );

endinterface

// File: rtl/serial_add_sub_add_digit.sv
// DIGIT-bit combinational ripple adder built from half-adder cells
// (two half adders plus an OR per bit), exposing the MSB sum bit.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module add_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             sum_msb
);

  // Carry is chained through per-bit blocks so each link is a distinct net.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic cin_s;
    logic cout_s;
    logic s1_s;
    logic c1_s;
    logic c2_s;

    if (i == 0) begin : g_first
      assign cin_s = cin;
    end else begin : g_next
      assign cin_s = g_bit[i-1].cout_s;
    end

    half_adder u_ha0 (.a(a[i]), .b(b[i]),  .s(s1_s),   .c(c1_s));
    half_adder u_ha1 (.a(s1_s), .b(cin_s), .s(sum[i]), .c(c2_s));

    assign cout_s = c1_s | c2_s;
  end

  assign cout    = g_bit[DIGIT-1].cout_s;
  assign sum_msb = sum[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract engine: DIGIT bits per clock through a registered
// carry, result and flags held in DONE until the consumer accepts them.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  serial_add_sub_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic             ready_r;
  logic             valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_next_s;
  logic             carry_r;
  logic             mode_r;
  logic             carry_flag_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] sum_s;
  logic             cout_s;
  logic             sum_msb_s;
  logic             accept_s;
  logic             step_s;
  logic             last_s;

  add_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_sh_r[DIGIT-1:0]),
    .b       (b_sh_r[DIGIT-1:0]),
    .cin     (carry_r),
    .sum     (sum_s),
    .cout    (cout_s),
    .sum_msb (sum_msb_s)
  );

  // Sum digits enter from the MSB end, so after STEPS cycles the LSB digit sits at bit 0.
  if (STEPS == 1) begin : g_single
    assign result_next_s = sum_s;
  end else begin : g_multi
    assign result_next_s = {sum_s, result_r[WIDTH-1:DIGIT]};
  end

  // Datapath strobes derived from the registered state.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = bus.i_valid;
    end else if (state_r == ST_RUN) begin
      step_s = 1'b1;
      last_s = (cnt_r == LAST_STEP);
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_valid) state_next_s = ST_RUN;
        else             state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == LAST_STEP) state_next_s = ST_DONE;
        else                    state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (bus.i_ready) state_next_s = ST_IDLE;
        else             state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == ST_IDLE);
      valid_r <= (state_next_s == ST_DONE);
      busy_r  <= (state_next_s == ST_RUN);
    end
  end

  // Working registers, result shift and flag capture on the final step.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      result_r     <= '0;
      carry_r      <= 1'b0;
      mode_r       <= 1'b0;
      carry_flag_r <= 1'b0;
      ovf_r        <= 1'b0;
      cnt_r        <= '0;
    end else if (accept_s) begin
      a_sh_r  <= bus.i_a;
      b_sh_r  <= (bus.i_mode == MODE_SUB) ? ~bus.i_b : bus.i_b;
      mode_r  <= bus.i_mode;
      carry_r <= bus.i_mode;
      cnt_r   <= '0;
    end else if (step_s) begin
      a_sh_r   <= a_sh_r >> DIGIT;
      b_sh_r   <= b_sh_r >> DIGIT;
      carry_r  <= cout_s;
      result_r <= result_next_s;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        // Subtraction reports borrow, the inverse of the final carry.
        carry_flag_r <= (mode_r == MODE_SUB) ? ~cout_s : cout_s;
        ovf_r        <= overflow_f(a_sh_r[DIGIT-1], b_sh_r[DIGIT-1], sum_msb_s);
      end else begin
        carry_flag_r <= carry_flag_r;
        ovf_r        <= ovf_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.o_ready    = ready_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_result   = result_r;
  assign bus.o_carry    = carry_flag_r;
  assign bus.o_overflow = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench driving a DIGIT=1 and a DIGIT=4 engine with identical
// operand streams; expected results come from plain integer arithmetic.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic       mode  = 1'b0;
  logic       rdy   = 1'b1;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  bit         rand_rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8)) if1 ();
  serial_add_sub_if #(.WIDTH(8)) if4 ();

  assign if1.i_valid = valid;
  assign if1.i_a     = a;
  assign if1.i_b     = b;
  assign if1.i_mode  = mode;
  assign if1.i_ready = rdy;
  assign if4.i_valid = valid;
  assign if4.i_a     = a;
  assign if4.i_b     = b;
  assign if4.i_mode  = mode;
  assign if4.i_ready = rdy;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1.slave));
  serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.i_clk(clk), .i_reset(rst), .bus(if4.slave));

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mm);
    exp_t e;
    int ua, ub, ur, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (mm == MODE_ADD) begin
      ur  = ua + ub;
      sr  = sa + sb;
      e.c = (ur > 255);
    end else begin
      ur  = ua - ub;
      sr  = sa - sb;
      e.c = (ua < ub);
    end
    e.res = 8'(ur);
    e.v   = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic im);
    int n;
    n = 0;
    while (!(if1.o_ready && if4.o_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("issue_ready", 32'(if1.o_ready && if4.o_ready), 32'd1);
    if (if1.o_ready && if4.o_ready) begin
      a     = ia;
      b     = ib;
      mode  = im;
      valid = 1'b1;
      q1.push_back(model(ia, ib, im));
      q4.push_back(model(ia, ib, im));
      tick();
      valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0 || !if1.o_ready || !if4.o_ready) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(q1.size() + q4.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_d1_ready"},  32'(if1.o_ready),    32'd1);
    chk({tag, "_d1_valid"},  32'(if1.o_valid),    32'd0);
    chk({tag, "_d1_busy"},   32'(if1.o_busy),     32'd0);
    chk({tag, "_d1_result"}, 32'(if1.o_result),   32'd0);
    chk({tag, "_d1_carry"},  32'(if1.o_carry),    32'd0);
    chk({tag, "_d1_ovf"},    32'(if1.o_overflow), 32'd0);
    chk({tag, "_d4_ready"},  32'(if4.o_ready),    32'd1);
    chk({tag, "_d4_valid"},  32'(if4.o_valid),    32'd0);
    chk({tag, "_d4_result"}, 32'(if4.o_result),   32'd0);
    chk({tag, "_d4_carry"},  32'(if4.o_carry),    32'd0);
  endtask

  // Monitor: every accepted result is popped and compared against the model.
  always @(negedge clk) begin
    exp_t e1;
    exp_t e4;
    if (!rst && if1.o_valid && rdy) begin
      chk("d1_result_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("d1_result",   32'(if1.o_result),   32'(e1.res));
        chk("d1_carry",    32'(if1.o_carry),    32'(e1.c));
        chk("d1_overflow", 32'(if1.o_overflow), 32'(e1.v));
      end
    end
    if (!rst && if4.o_valid && rdy) begin
      chk("d4_result_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("d4_result",   32'(if4.o_result),   32'(e4.res));
        chk("d4_carry",    32'(if4.o_carry),    32'(e4.c));
        chk("d4_overflow", 32'(if4.o_overflow), 32'(e4.v));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int         lat1;
    int         lat4;
    int         n;
    bit         saw_valid;
    logic [7:0] s_res;
    logic       s_c;
    logic       s_v;
    logic [7:0] s4_res;

    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("por");
    rst = 1'b0;
    tick();

    // Latency: DIGIT=1 needs 8 steps, DIGIT=4 needs 2.
    issue(8'h35, 8'h4A, MODE_ADD);
    chk("d1_busy_after_accept",  32'(if1.o_busy),  32'd1);
    chk("d1_ready_after_accept", 32'(if1.o_ready), 32'd0);
    lat1 = 0;
    lat4 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if4.o_valid && lat4 == 0) lat4 = i;
      if (if1.o_valid && lat1 == 0) lat1 = i;
    end
    chk("d1_latency", 32'(lat1), 32'd8);
    chk("d4_latency", 32'(lat4), 32'd2);
    drain();

    issue(8'h7F, 8'h01, MODE_ADD); drain();
    issue(8'hFF, 8'h01, MODE_ADD); drain();
    issue(8'h10, 8'h20, MODE_SUB); drain();
    issue(8'h80, 8'h01, MODE_SUB); drain();
    issue(8'h00, 8'h01, MODE_SUB); drain();

    // Backpressure: outputs frozen in DONE, new operands ignored.
    rdy = 1'b0;
    issue(8'hC3, 8'h5A, MODE_SUB);
    n = 0;
    while (!if1.o_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reached_done", 32'(if1.o_valid), 32'd1);
    s_res  = if1.o_result;
    s_c    = if1.o_carry;
    s_v    = if1.o_overflow;
    s4_res = if4.o_result;
    a      = 8'hAA;
    b      = 8'h11;
    mode   = MODE_ADD;
    valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_d1_valid",  32'(if1.o_valid),    32'd1);
      chk("bp_d1_ready",  32'(if1.o_ready),    32'd0);
      chk("bp_d1_result", 32'(if1.o_result),   32'(s_res));
      chk("bp_d1_carry",  32'(if1.o_carry),    32'(s_c));
      chk("bp_d1_ovf",    32'(if1.o_overflow), 32'(s_v));
      chk("bp_d4_valid",  32'(if4.o_valid),    32'd1);
      chk("bp_d4_result", 32'(if4.o_result),   32'(s4_res));
      chk("bp_d4_busy",   32'(if4.o_busy),     32'd0);
    end
    valid = 1'b0;
    rdy   = 1'b1;
    tick();
    chk("bp_release_d1_ready", 32'(if1.o_ready), 32'd1);
    chk("bp_release_d1_valid", 32'(if1.o_valid), 32'd0);
    chk("bp_release_d4_ready", 32'(if4.o_ready), 32'd1);
    chk("bp_pending_after_release", 32'(q1.size() + q4.size()), 32'd0);

    // Reset while the DIGIT=1 engine is in its third step.
    issue(8'h55, 8'h33, MODE_ADD);
    tick();
    tick();
    chk("rst_d1_busy_before", 32'(if1.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrun");
    q1.delete();
    q4.delete();
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_valid = saw_valid | if1.o_valid | if4.o_valid;
    end
    chk("rst_no_valid_pulse", 32'(saw_valid), 32'd0);
    issue(8'h01, 8'h01, MODE_ADD);
    drain();

    // Randomised operands with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    rdy = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
